// File: rtl/dsm_pkg.sv
// Shared types and MASH 1-1-1 range defaults for the delta-sigma
// fraction recovery path.
package dsm_pkg;

    // Windowing controller states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dsm_state_t;

    // MASH 1-1-1 output spans -3..+4, which fits a 4-bit signed sample
    localparam int DSM_IN_W   = 4;
    localparam int DSM_IN_MIN = -3;
    localparam int DSM_IN_MAX = 4;

endpackage

// File: rtl/dsm_frac_decimator.sv
// Integrates the signed modulator stream over 2^LOG2_WIN accepted samples
// and presents each window sum as the recovered fractional word.
module dsm_frac_decimator
    import dsm_pkg::*;
#(
    parameter int IN_W     = DSM_IN_W,
    parameter int LOG2_WIN = 10,
    parameter int IN_MIN   = DSM_IN_MIN,
    parameter int IN_MAX   = DSM_IN_MAX,
    localparam int ACC_W   = IN_W + LOG2_WIN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  dsm_in,
    output logic signed [ACC_W-1:0] frac_out,
    output logic                    frac_valid,
    output logic                    busy,
    output logic [7:0]              win_count,
    output logic                    range_err
);

    localparam logic signed [IN_W-1:0] LO = IN_W'(IN_MIN);
    localparam logic signed [IN_W-1:0] HI = IN_W'(IN_MAX);

    dsm_state_t              state;
    logic signed [ACC_W-1:0] acc;
    logic [LOG2_WIN-1:0]     cnt;

    logic signed [ACC_W-1:0] sample_ext;
    logic                    last_sample;
    logic                    out_of_range;

    // Sample decode: sign extension, window-end and legality detection
    always_comb begin
        sample_ext   = ACC_W'(dsm_in);
        last_sample  = in_valid && (cnt == '1);
        out_of_range = (dsm_in < LO) || (dsm_in > HI);
    end

    // Window controller: accumulate, close windows, abort on en low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            frac_out   <= '0;
            frac_valid <= 1'b0;
            busy       <= 1'b0;
            win_count  <= '0;
            range_err  <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            frac_out   <= '0;
            frac_valid <= 1'b0;
            busy       <= 1'b0;
            win_count  <= '0;
            range_err  <= 1'b0;
        end else begin
            frac_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (in_valid && out_of_range) begin
                        range_err <= 1'b1;
                    end
                    if (last_sample) begin
                        // Final sample joins the sum; next window starts at once
                        frac_out   <= acc + sample_ext;
                        frac_valid <= 1'b1;
                        acc        <= '0;
                        cnt        <= '0;
                        if (win_count != 8'hFF) begin
                            win_count <= win_count + 8'd1;
                        end
                    end else if (!en) begin
                        acc <= '0;
                        cnt <= '0;
                    end else if (in_valid) begin
                        acc <= acc + sample_ext;
                        cnt <= cnt + 1'b1;
                    end
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsm_frac_decimator.sv
// Directed, table-driven bench for dsm_frac_decimator with a 16-sample
// window, plus hand sequences for async reset and gapped input.
module tb_dsm_frac_decimator;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              en;
    logic              in_valid;
    logic signed [3:0] dsm_in;
    logic signed [7:0] frac_out;
    logic              frac_valid;
    logic              busy;
    logic [7:0]        win_count;
    logic              range_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              en;
        logic              iv;
        logic              clr;
        logic signed [3:0] d;
        int                fo;
        logic              fv;
        logic              busy;
        int                wc;
        logic              re;
    } vec_t;

    vec_t vecs[$];

    dsm_frac_decimator #(
        .IN_W    (4),
        .LOG2_WIN(4),
        .IN_MIN  (-3),
        .IN_MAX  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .en        (en),
        .in_valid  (in_valid),
        .dsm_in    (dsm_in),
        .frac_out  (frac_out),
        .frac_valid(frac_valid),
        .busy      (busy),
        .win_count (win_count),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int fo, input logic fv,
                             input logic b, input int wc, input logic re);
        check({tag, " frac_out"}, int'(frac_out), fo);
        check({tag, " frac_valid"}, int'(frac_valid), int'(fv));
        check({tag, " busy"}, int'(busy), int'(b));
        check({tag, " win_count"}, int'(win_count), wc);
        check({tag, " range_err"}, int'(range_err), int'(re));
    endtask

    task automatic drive(input logic e, input logic iv, input logic c,
                         input logic signed [3:0] d);
        en       = e;
        in_valid = iv;
        clear    = c;
        dsm_in   = d;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic e, input logic iv, input logic c,
                                input logic signed [3:0] d, input int fo,
                                input logic fv, input logic b, input int wc,
                                input logic re);
        vec_t v;
        v.en = e; v.iv = iv; v.clr = c; v.d = d;
        v.fo = fo; v.fv = fv; v.busy = b; v.wc = wc; v.re = re;
        vecs.push_back(v);
    endfunction

    initial begin
        // Test 1: constant +1 over one window
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 16; i++)
            add(1, 1, 0, 1, (i == 16) ? 16 : 0, i == 16, 1,
                (i == 16) ? 1 : 0, 0);
        add(1, 0, 0, 0, 16, 0, 1, 1, 0);
        // Test 2: {+2,-1} over two back-to-back windows
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 32; i++)
            add(1, 1, 0, (i % 2 == 1) ? 4'sd2 : -4'sd1, (i < 16) ? 0 : 8,
                (i == 16) || (i == 32), 1,
                (i < 16) ? 0 : (i < 32) ? 1 : 2, 0);
        // Test 3: abort after 10 samples, then a -3 window
        for (int i = 1; i <= 10; i++)
            add(1, 1, 0, 3, 8, 0, 1, 2, 0);
        add(0, 0, 0, 0, 8, 0, 0, 2, 0);
        add(0, 1, 0, 3, 8, 0, 0, 2, 0);
        add(1, 0, 0, 0, 8, 0, 1, 2, 0);
        for (int i = 1; i <= 16; i++)
            add(1, 1, 0, -3, (i == 16) ? -48 : 8, i == 16, 1,
                (i == 16) ? 3 : 2, 0);
        add(0, 0, 0, 0, -48, 0, 0, 3, 0);
        // Test 4: illegal -5 mid-window, then clear
        add(1, 0, 0, 0, -48, 0, 1, 3, 0);
        for (int i = 1; i <= 16; i++)
            add(1, 1, 0, (i == 5) ? -4'sd5 : 4'sd1, (i == 16) ? 10 : -48,
                i == 16, 1, (i == 16) ? 4 : 3, i >= 5);
        add(1, 1, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        // en dropping on the final-sample edge still completes the window
        for (int i = 1; i <= 15; i++)
            add(1, 1, 0, 2, 0, 0, 1, 0, 0);
        add(0, 1, 0, 2, 32, 1, 0, 1, 0);
        add(0, 0, 0, 0, 32, 0, 0, 1, 0);

        rst = 1'b1; clear = 1'b0; en = 1'b0; in_valid = 1'b0; dsm_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].iv, vecs[i].clr, vecs[i].d);
            check_all($sformatf("vec%0d", i), vecs[i].fo, vecs[i].fv,
                      vecs[i].busy, vecs[i].wc, vecs[i].re);
        end

        // Test 5: async reset between edges mid-window
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 1);
        #3;
        rst = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 0);
        check("rst_reen busy", int'(busy), 1);
        for (int i = 1; i <= 16; i++) begin
            drive(1, 1, 0, 1);
            check($sformatf("rst_win s%0d frac_valid", i), int'(frac_valid),
                  (i == 16) ? 1 : 0);
        end
        check("rst_win frac_out", int'(frac_out), 16);
        check("rst_win win_count", int'(win_count), 1);

        // Test 6: in_valid duty 1/3, junk on idle cycles must be ignored
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        for (int k = 0; k < 48; k++) begin
            drive(1, k % 3 == 0, 0, (k % 3 == 0) ? 4'sd4 : 4'sd7);
            check($sformatf("gap k%0d frac_valid", k), int'(frac_valid),
                  (k == 45) ? 1 : 0);
        end
        check("gap frac_out", int'(frac_out), 64);
        check("gap win_count", int'(win_count), 1);
        check("gap range_err", int'(range_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
